// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the arithmetic-mux front end.
//
// Contents:
//   seq_state_t  - operand sequencer FSM states; the encodings are visible on LEDs
//   OP_*         - selector codes understood by the arithmetic mux
//   is_legal_state - true for the five defined state codes
package alu_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } seq_state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_CORR = 3'b100;

  // Codes 5..7 are never produced by the FSM; they can only appear after an upset.
  function automatic logic is_legal_state(input logic [2:0] code);
    return (code <= 3'd4);
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_edge.sv
// Push-button conditioner: 2-flop synchronizer followed by a rising-edge detector.
//
// Ports:
//   clk    in  1  system clock
//   rst    in  1  synchronous, active-high reset; clears every flop
//   raw    in  1  raw button level, asynchronous to clk
//   pulse  out 1  one-cycle pulse, high 3 clk edges after the raw 0->1 transition
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // The pulse is registered so that a held button yields exactly one pulse and the
  // consumer sees a clean flop output rather than a gate off the synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer in front of the combinational arithmetic mux. Operands A and B and
// the selector are captured from switches one button press at a time; the mux result is
// registered for display one cycle after the selector is captured.
//
// Ports:
//   clk        in  1      system clock
//   rst        in  1      synchronous, active-high reset
//   sw         in  N      operand switches (quasi-static)
//   op_sw      in  3      selector switches (quasi-static)
//   btn_next   in  1      raw step button
//   btn_clear  in  1      raw clear button
//   mux_res    in  N      result from the arithmetic mux
//   a_q        out N      operand A to the mux
//   b_q        out N      operand B to the mux
//   s_q        out 3      selector to the mux
//   result_q   out N      registered result for display
//   state_o    out 3      current FSM state code
//   done       out 1      high while result_q holds a fresh result
//   op_count   out CNT_W  completed operations, wraps
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     sw,
  input  logic [2:0]       op_sw,
  input  logic             btn_next,
  input  logic             btn_clear,
  input  logic [N-1:0]     mux_res,
  output logic [N-1:0]     a_q,
  output logic [N-1:0]     b_q,
  output logic [2:0]       s_q,
  output logic [N-1:0]     result_q,
  output logic [2:0]       state_o,
  output logic             done,
  output logic [CNT_W-1:0] op_count
);

  seq_state_t state;
  logic       next_pulse;
  logic       clear_pulse;

  btn_edge u_next (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_next),
    .pulse (next_pulse)
  );

  btn_edge u_clear (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_clear),
    .pulse (clear_pulse)
  );

  assign state_o = state;

  // Priority is rst, then clear, then the per-state step. Switches are only sampled
  // while next_pulse is high, so no switch synchronizer is needed. op_count survives
  // clear; only rst zeroes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      result_q <= '0;
      done     <= 1'b0;
      op_count <= '0;
    end else if (clear_pulse) begin
      state    <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      result_q <= '0;
      done     <= 1'b0;
    end else if (!is_legal_state(state)) begin
      state <= S_A;
    end else begin
      case (state)
        S_A: begin
          if (next_pulse) begin
            a_q   <= sw;
            state <= S_B;
          end
        end
        S_B: begin
          if (next_pulse) begin
            b_q   <= sw;
            state <= S_OP;
          end
        end
        S_OP: begin
          if (next_pulse) begin
            s_q   <= op_sw;
            state <= S_EXEC;
          end
        end
        // s_q was written on the previous edge, so mux_res now reflects it.
        S_EXEC: begin
          result_q <= mux_res;
          done     <= 1'b1;
          op_count <= op_count + CNT_W'(1);
          state    <= S_SHOW;
        end
        S_SHOW: begin
          if (next_pulse) begin
            done  <= 1'b0;
            state <= S_A;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer. A behavioural arithmetic mux closes the
// loop on mux_res; expected values are hand-computed.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [2:0] op_sw;
  logic       btn_next;
  logic       btn_clear;
  logic [3:0] mux_res;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [2:0] s_q;
  logic [3:0] result_q;
  logic [2:0] state_o;
  logic       done;
  logic [7:0] op_count;

  int numCompared   = 0;
  int numMismatched = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.N(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .op_sw     (op_sw),
    .btn_next  (btn_next),
    .btn_clear (btn_clear),
    .mux_res   (mux_res),
    .a_q       (a_q),
    .b_q       (b_q),
    .s_q       (s_q),
    .result_q  (result_q),
    .state_o   (state_o),
    .done      (done),
    .op_count  (op_count)
  );

  // Behavioural stand-in for the combinational arithmetic mux (N=4, results truncated)
  always_comb begin
    mux_res = 4'd0;
    case (s_q)
      OP_ADD:  mux_res = a_q + b_q;
      OP_SUB:  mux_res = a_q - b_q;
      OP_DIV:  mux_res = (b_q == 4'd0) ? 4'hF : a_q / b_q;
      OP_MUL:  mux_res = 4'(a_q * b_q);
      OP_CORR: mux_res = a_q ^ b_q;
      default: mux_res = 4'd0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Sets the switches and holds btn_next long enough for the FSM to act on the pulse.
  // Returns right after the FSM edge; callers idle before the next press.
  task automatic applyStimulus(input logic [3:0] swVal, input logic [2:0] opVal);
    sw       = swVal;
    op_sw    = opVal;
    btn_next = 1'b1;
    repeat (4) @(negedge clk);
    btn_next = 1'b0;
  endtask

  task automatic pressClear();
    btn_clear = 1'b1;
    repeat (4) @(negedge clk);
    btn_clear = 1'b0;
  endtask

  task automatic runOp(input logic [3:0] aVal, input logic [3:0] bVal,
                       input logic [2:0] opVal);
    applyStimulus(aVal, 3'd0); idle(3);
    applyStimulus(bVal, 3'd0); idle(3);
    applyStimulus(4'd0, opVal); idle(3);
    applyStimulus(4'd0, 3'd0); idle(3);
  endtask

  initial begin
    rst = 1'b1; sw = '0; op_sw = '0; btn_next = 1'b0; btn_clear = 1'b0;
    idle(3);
    rst = 1'b0;
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_a", a_q, 0);
    checkOutput("rst_b", b_q, 0);
    checkOutput("rst_s", s_q, 0);
    checkOutput("rst_result", result_q, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_count", op_count, 0);
    idle(2);

    // Add 5+3
    applyStimulus(4'd5, 3'd0);
    checkOutput("add_state_b", state_o, 1);
    checkOutput("add_a", a_q, 5);
    idle(3);
    applyStimulus(4'd3, 3'd0);
    checkOutput("add_state_op", state_o, 2);
    checkOutput("add_b", b_q, 3);
    idle(3);
    applyStimulus(4'd0, OP_ADD);
    checkOutput("add_state_exec", state_o, 3);
    checkOutput("add_s", s_q, 0);
    checkOutput("add_done_early", done, 0);
    @(negedge clk);
    checkOutput("add_result", result_q, 8);
    checkOutput("add_done", done, 1);
    checkOutput("add_count", op_count, 1);
    checkOutput("add_state_show", state_o, 4);
    idle(3);

    // Sub 7-2, then step out of SHOW
    applyStimulus(4'd0, 3'd0); idle(3);
    checkOutput("show_to_a", state_o, 0);
    applyStimulus(4'd7, 3'd0); idle(3);
    applyStimulus(4'd2, 3'd0); idle(3);
    applyStimulus(4'd0, OP_SUB); idle(1);
    checkOutput("sub_result", result_q, 5);
    checkOutput("sub_count", op_count, 2);
    idle(2);
    applyStimulus(4'd0, 3'd0);
    checkOutput("sub_next_state", state_o, 0);
    checkOutput("sub_next_done", done, 0);
    checkOutput("sub_keep_a", a_q, 7);
    idle(3);

    // Add overflow 9+9 wraps to 2
    applyStimulus(4'd9, 3'd0); idle(3);
    applyStimulus(4'd9, 3'd0); idle(3);
    applyStimulus(4'd0, OP_ADD); idle(1);
    checkOutput("ovf_result", result_q, 2);
    checkOutput("ovf_count", op_count, 3);
    idle(2);
    applyStimulus(4'd0, 3'd0); idle(3);

    // Mul 3*5 = 15, left in SHOW
    applyStimulus(4'd3, 3'd0); idle(3);
    applyStimulus(4'd5, 3'd0); idle(3);
    applyStimulus(4'd0, OP_MUL); idle(1);
    checkOutput("mul_result", result_q, 15);
    checkOutput("mul_count", op_count, 4);
    idle(2);

    // Held next button: one pulse only, SHOW -> A
    btn_next = 1'b1;
    idle(50);
    checkOutput("hold_state", state_o, 0);
    checkOutput("hold_done", done, 0);
    btn_next = 1'b0;
    idle(3);

    // Clear in S_OP with s_q and result_q nonzero
    applyStimulus(4'd6, 3'd0); idle(3);
    applyStimulus(4'd1, 3'd0); idle(3);
    checkOutput("clr_pre_state", state_o, 2);
    checkOutput("clr_pre_s", s_q, 3);
    pressClear();
    checkOutput("clr_state", state_o, 0);
    checkOutput("clr_a", a_q, 0);
    checkOutput("clr_b", b_q, 0);
    checkOutput("clr_s", s_q, 0);
    checkOutput("clr_result", result_q, 0);
    checkOutput("clr_count", op_count, 4);
    idle(3);

    // Clear and next in the same cycle: clear wins
    applyStimulus(4'd2, 3'd0); idle(3);
    checkOutput("both_pre_state", state_o, 1);
    btn_next  = 1'b1;
    btn_clear = 1'b1;
    repeat (4) @(negedge clk);
    btn_next  = 1'b0;
    btn_clear = 1'b0;
    checkOutput("both_state", state_o, 0);
    checkOutput("both_a", a_q, 0);
    idle(3);

    // Counter wrap
    for (int i = 0; i < 251; i++) runOp(4'd1, 4'd1, OP_ADD);
    checkOutput("cnt_255", op_count, 255);
    runOp(4'd4, 4'd2, OP_DIV);
    checkOutput("cnt_wrap", op_count, 0);
    checkOutput("div_result", result_q, 2);

    // Reset while in S_EXEC
    applyStimulus(4'd4, 3'd0); idle(3);
    applyStimulus(4'd3, 3'd0); idle(3);
    applyStimulus(4'd0, OP_CORR);
    checkOutput("exec_rst_pre", state_o, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("exec_rst_state", state_o, 0);
    checkOutput("exec_rst_a", a_q, 0);
    checkOutput("exec_rst_s", s_q, 0);
    checkOutput("exec_rst_result", result_q, 0);
    checkOutput("exec_rst_done", done, 0);
    checkOutput("exec_rst_count", op_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
